// File: rtl/led_pwm_fader.sv
// led_pwm_fader: drives each LED with PWM whose brightness level ramps linearly
// toward the on/off state commanded by the PIO pattern instead of snapping.
// Optional feature: define LED_PWM_FADER_SYNC_EN to pass in_pattern through a
// 2-flop synchronizer before it is used as the ramp target.
module led_pwm_fader #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned STEP_DIV = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] in_pattern,
  output logic [WIDTH-1:0] led_out,
  output logic             busy
);

  // Divider needs at least one bit so STEP_DIV == 1 still elaborates.
  localparam int unsigned DivBits = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DivBits-1:0]  DivLast  = DivBits'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] LevelMax = {PWM_BITS{1'b1}};

  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [DivBits-1:0]  div_cnt_q;
  logic                tick;
  logic [WIDTH-1:0]    target;

  logic [PWM_BITS-1:0] level_q [WIDTH];
  logic [PWM_BITS-1:0] level_d [WIDTH];

  logic [WIDTH-1:0]    led_q, led_d;
  logic                busy_q, busy_d;

`ifdef LED_PWM_FADER_SYNC_EN
  logic [WIDTH-1:0] sync_q1, sync_q2;

  // Two-stage synchronizer; keeps sampling while disabled so the target is
  // already settled when enable returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= in_pattern;
      sync_q2 <= sync_q1;
    end
  end

  assign target = sync_q2;
`else
  assign target = in_pattern;
`endif

  // Free-running PWM counter; only reset stops it, enable does not.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
    end
  end

  assign tick = (div_cnt_q == DivLast);

  // Step divider; cleared while disabled so the first tick after re-enable
  // lands a full STEP_DIV cycles later.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      div_cnt_q <= '0;
    end else if (tick) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + DivBits'(1);
    end
  end

  // Next level, PWM compare and endpoint check for every LED.
  always_comb begin
    led_d  = '0;
    busy_d = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      level_d[i] = level_q[i];
      if (tick) begin
        // Saturating step toward the endpoint; a reversed target simply
        // turns the ramp around from the current level.
        if (target[i] && (level_q[i] != LevelMax)) begin
          level_d[i] = level_q[i] + PWM_BITS'(1);
        end else if (!target[i] && (level_q[i] != '0)) begin
          level_d[i] = level_q[i] - PWM_BITS'(1);
        end
      end
      // MAX must be solidly lit even when pwm_cnt is also MAX.
      led_d[i] = (level_q[i] == LevelMax) || (level_q[i] > pwm_cnt_q);
      if (level_q[i] != (target[i] ? LevelMax : '0)) begin
        busy_d = 1'b1;
      end
    end
  end

  // Brightness levels; disable clears them so ramps restart from dark.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      for (int i = 0; i < WIDTH; i++) begin
        level_q[i] <= '0;
      end
    end else begin
      level_q <= level_d;
    end
  end

  // Registered outputs, one cycle behind the level/pwm state.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      led_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      led_q  <= led_d;
      busy_q <= busy_d;
    end
  end

  assign led_out = led_q;
  assign busy    = busy_q;

endmodule
